conv_result_streamer: RTL and testbench

CONV_RESULT_STREAMER -- requirements
Module: conv_result_streamer

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_stream_idx.sv | 74 +++++++
 rtl/conv_result_streamer.sv | 126 ++++++++++++
 tb/tb_conv_result_streamer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv result streamer: output geometry helpers,
// result word width helper and the streaming FSM states.
package conv_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

   // A valid convolution shrinks each edge by the even part of the kernel edge
   function automatic int out_dim_f(input int image_size, input int kernel_size);
      return image_size - (kernel_size - (kernel_size % 2));
   endfunction

   function automatic int rw_f(input int word_length);
      return 2 * word_length;
   endfunction

   function automatic int cnt_w_f(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_stream_idx.sv
// Row/column/linear-index position counter for the result streamer.
// Clear has priority over advance; the position wraps to 0 after the last result.
module conv_stream_idx
   import conv_pkg::*;
#(
   parameter int out_dim = 32,
   localparam int CW = cnt_w_f(out_dim),
   localparam int IW = cnt_w_f(out_dim * out_dim)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_i,
   input  logic          advance_i,
   output logic [IW-1:0] idx_o,
   output logic          row_end_o,
   output logic          last_o
);

   logic [CW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          col_last_s;
   logic          row_last_s;

   assign col_last_s = (col_q == CW'(out_dim - 1));
   assign row_last_s = (row_q == CW'(out_dim - 1));
   assign row_end_o  = col_last_s;
   assign last_o     = col_last_s && row_last_s;
   assign idx_o      = idx_q;

   // Position registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
         idx_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
         idx_q <= idx_d;
      end
   end

   // Next position: column wraps into the row, whole frame wraps to 0
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      idx_d = idx_q;
      if (clear_i) begin
         row_d = '0;
         col_d = '0;
         idx_d = '0;
      end else if (advance_i) begin
         if (col_last_s) begin
            col_d = '0;
            if (row_last_s) begin
               row_d = '0;
               idx_d = '0;
            end else begin
               row_d = row_q + 1'b1;
               idx_d = idx_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
            idx_d = idx_q + 1'b1;
         end
      end else begin
         row_d = row_q;
         col_d = col_q;
         idx_d = idx_q;
      end
   end

endmodule

// File: rtl/conv_result_streamer.sv
// Streams a captured frame of convolution results one word per handshake.
// Optional build macro CONV_RESULT_RELU_EN clamps negative results to zero.
module conv_result_streamer
   import conv_pkg::*;
#(
   parameter int word_length = 8,
   parameter int kernel_size = 5,
   parameter int image_size  = 36,
   localparam int OUT_DIM = out_dim_f(image_size, kernel_size),
   localparam int N       = OUT_DIM * OUT_DIM,
   localparam int RW      = rw_f(word_length),
   localparam int IW      = cnt_w_f(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [N*RW-1:0] frame_in,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [RW-1:0]   out_data,
   output logic            out_row_end,
   output logic            out_last,
   output logic            busy,
   output logic            overrun
);

   state_e          state_q, state_d;
   logic            overrun_q, overrun_d;
   logic [N*RW-1:0] frame_q;
   logic            capture_s;
   logic            clear_s;
   logic            advance_s;
   logic [IW-1:0]   idx_s;
   logic            row_end_s;
   logic            last_s;
   logic [RW-1:0]   result_s;
   logic [RW-1:0]   word_s;

   conv_stream_idx #(
      .out_dim (OUT_DIM)
   ) u_idx (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (clear_s),
      .advance_i (advance_s),
      .idx_o     (idx_s),
      .row_end_o (row_end_s),
      .last_o    (last_s)
   );

   // FSM state and overrun pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         overrun_q <= overrun_d;
      end
   end

   // Frame storage holds no control state, so it is left unreset
   always_ff @(posedge clk) begin
      if (capture_s) begin
         frame_q <= frame_in;
      end else begin
         frame_q <= frame_q;
      end
   end

   // Next state; a load is only accepted when idle or on the final transfer
   always_comb begin
      state_d   = state_q;
      overrun_d = 1'b0;
      capture_s = 1'b0;
      clear_s   = 1'b0;
      advance_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               capture_s = 1'b1;
               clear_s   = 1'b1;
               state_d   = STREAM;
            end else begin
               state_d   = IDLE;
            end
         end
         STREAM: begin
            if (out_ready && last_s) begin
               clear_s = 1'b1;
               if (load) begin
                  capture_s = 1'b1;
                  state_d   = STREAM;
               end else begin
                  state_d   = IDLE;
               end
            end else if (out_ready) begin
               advance_s = 1'b1;
               overrun_d = load;
            end else begin
               overrun_d = load;
            end
         end
         default: begin
            state_d = IDLE;
            clear_s = 1'b1;
         end
      endcase
   end

   assign result_s = frame_q[RW*int'(idx_s) +: RW];

`ifdef CONV_RESULT_RELU_EN
   assign word_s = result_s[RW-1] ? {RW{1'b0}} : result_s;
`else
   assign word_s = result_s;
`endif

   assign out_valid   = (state_q == STREAM);
   assign busy        = (state_q == STREAM);
   assign out_data    = out_valid ? word_s : {RW{1'b0}};
   assign out_row_end = out_valid && row_end_s;
   assign out_last    = out_valid && last_s;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Self-checking bench for conv_result_streamer: a table of short handshake steps,
// directed corner sequences and randomized traffic against a word-queue model.
module tb_conv_result_streamer;

   localparam int WL = 8;
   localparam int KS = 5;
   localparam int IS = 36;
   localparam int OD = 32;
   localparam int N  = OD * OD;
   localparam int RW = 2 * WL;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            load = 1'b0;
   logic            out_ready = 1'b0;
   logic [N*RW-1:0] frame_in = '0;
   logic            out_valid;
   logic [RW-1:0]   out_data;
   logic            out_row_end;
   logic            out_last;
   logic            busy;
   logic            overrun;

   int n_cmp = 0;
   int n_bad = 0;

   conv_result_streamer #(
      .word_length (WL),
      .kernel_size (KS),
      .image_size  (IS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .frame_in    (frame_in),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_row_end (out_row_end),
      .out_last    (out_last),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   // Reference: the frame offered on frame_in, the frame being streamed, and
   // the position of the word currently presented.
   logic [RW-1:0] pend [N];
   logic [RW-1:0] held [N];
   bit            m_stream = 1'b0;
   int            m_k = 0;
   bit            m_ovr = 1'b0;

   function automatic logic [RW-1:0] shaped(input logic [RW-1:0] v);
`ifdef CONV_RESULT_RELU_EN
      return ($signed(v) < 0) ? {RW{1'b0}} : v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      logic [20:0]   exp;
      logic [20:0]   act;
      logic [RW-1:0] ed;
      ed  = m_stream ? shaped(held[m_k]) : {RW{1'b0}};
      exp = {m_stream, m_stream && ((m_k % OD) == OD - 1), m_stream && (m_k == N - 1),
             m_stream, m_ovr, ed};
      act = {out_valid, out_row_end, out_last, busy, overrun, out_data};
      check(tag, {11'd0, act}, {11'd0, exp});
   endtask

   // Apply the rules for one rising edge with the given inputs
   task automatic model_edge(input bit ld, input bit rdy);
      bit acc;
      acc   = 1'b0;
      m_ovr = 1'b0;
      if (!m_stream) begin
         acc = ld;
      end else if (rdy && m_k == N - 1) begin
         acc = ld;
         if (!ld) m_stream = 1'b0;
      end else if (rdy) begin
         m_k   = m_k + 1;
         m_ovr = ld;
      end else begin
         m_ovr = ld;
      end
      if (acc) begin
         held     = pend;
         m_k      = 0;
         m_stream = 1'b1;
      end
   endtask

   // Called at a falling edge: drive, clock once, then compare at the next falling edge
   task automatic cycle(input bit ld, input bit rdy, input string tag);
      load      = ld;
      out_ready = rdy;
      @(posedge clk);
      model_edge(ld, rdy);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic fill(input int kind);
      for (int k = 0; k < N; k++) begin
         case (kind)
            0:       pend[k] = RW'(k);
            1:       pend[k] = RW'(2000 + k);
            2:       pend[k] = RW'($urandom);
            default: pend[k] = RW'(k);
         endcase
         frame_in[k*RW +: RW] = pend[k];
      end
   endtask

   task automatic drain(input string tag);
      for (int c = 0; c < 2 * N && m_stream; c++) cycle(1'b0, 1'b1, tag);
      if (m_stream) check({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic run_until(input int k, input string tag);
      for (int c = 0; c < 2 * N && m_stream && m_k != k; c++) cycle(1'b0, 1'b1, tag);
      if (m_k != k) check({tag, "_reach"}, 32'(m_k), 32'(k));
   endtask

   typedef struct {
      bit          ld;
      bit          rdy;
      bit          alt;
      bit          v;
      logic [15:0] d;
      bit          re;
      bit          la;
      bit          ov;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int            words;
      int            re_cnt;
      int            la_cnt;
      bit            prev_v;
      logic [RW-1:0] prev_d;
      bit            rdy;
      bit            ld;

      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0};

      // Reset state
      #1 rst = 1'b1;
      #2;
      check("reset_state", {11'd0, out_valid, out_row_end, out_last, busy, overrun, out_data},
            32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table: load, stalls and two ignored loads (one offering a different frame)
      fill(0);
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].alt) fill(1);
         cycle(tbl[i].ld, tbl[i].rdy, "tbl_model");
         check($sformatf("tbl_step%0d", i),
               {11'd0, out_valid, out_row_end, out_last, overrun, out_data},
               {11'd0, tbl[i].v, tbl[i].re, tbl[i].la, tbl[i].ov, tbl[i].d});
      end
      drain("tbl_drain");

      // Full frame at constant ready
      fill(0);
      cycle(1'b1, 1'b1, "full_load");
      words  = 0;
      re_cnt = 0;
      la_cnt = 0;
      for (int c = 0; c < N + 64 && m_stream; c++) begin
         if (out_valid) begin
            words++;
            if (out_row_end) re_cnt++;
            if (out_last) la_cnt++;
         end
         cycle(1'b0, 1'b1, "full_run");
      end
      check("full_words", 32'(words), 32'(N));
      check("full_row_ends", 32'(re_cnt), 32'(OD));
      check("full_lasts", 32'(la_cnt), 32'd1);
      check("full_idle_valid", {31'd0, out_valid}, 32'd0);

      // Ready pattern 1,0,0,1 with stall stability
      fill(0);
      cycle(1'b1, 1'b1, "tog_load");
      for (int c = 0; c < 5 * N && m_stream; c++) begin
         rdy    = ((c % 4) == 0) || ((c % 4) == 3);
         prev_v = out_valid;
         prev_d = out_data;
         cycle(1'b0, rdy, "tog_run");
         if (prev_v && !rdy) check("tog_stall_data", {16'd0, out_data}, {16'd0, prev_d});
      end
      if (m_stream) check("tog_timeout", 32'd1, 32'd0);

      // Load during word 100 is rejected
      fill(0);
      cycle(1'b1, 1'b1, "ovr_load");
      run_until(100, "ovr_run");
      fill(1);
      cycle(1'b1, 1'b1, "ovr_hit");
      check("ovr_pulse", {31'd0, overrun}, 32'd1);
      check("ovr_data101", {16'd0, out_data}, 32'd101);
      cycle(1'b0, 1'b1, "ovr_after");
      check("ovr_pulse_end", {31'd0, overrun}, 32'd0);
      check("ovr_data102", {16'd0, out_data}, 32'd102);
      drain("ovr_drain");

      // Back-to-back frame on the final transfer
      fill(0);
      cycle(1'b1, 1'b1, "b2b_load");
      run_until(N - 1, "b2b_run");
      check("b2b_last", {31'd0, out_last}, 32'd1);
      fill(1);
      cycle(1'b1, 1'b1, "b2b_hit");
      check("b2b_valid", {31'd0, out_valid}, 32'd1);
      check("b2b_data", {16'd0, out_data}, 32'd2000);
      drain("b2b_drain");

      // Reset mid-frame after word 500
      fill(0);
      cycle(1'b1, 1'b1, "rst_load");
      run_until(501, "rst_run");
      #2 rst = 1'b1;
      #1;
      m_stream = 1'b0;
      m_k      = 0;
      m_ovr    = 1'b0;
      check("rst_mid_outs",
            {11'd0, out_valid, out_row_end, out_last, busy, overrun, out_data}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 1'b1, "rst_idle");
      fill(1);
      cycle(1'b1, 1'b1, "rst_reload");
      check("rst_first_word", {16'd0, out_data}, 32'd2000);
      drain("rst_drain");

      // Negative first result
      fill(0);
      pend[0]              = 16'hFFF6;
      frame_in[RW-1:0]     = 16'hFFF6;
      cycle(1'b1, 1'b0, "neg_load");
`ifdef CONV_RESULT_RELU_EN
      check("neg_word0", {16'd0, out_data}, 32'h0000);
`else
      check("neg_word0", {16'd0, out_data}, 32'hFFF6);
`endif
      drain("neg_drain");

      // Randomized traffic and frames
      fill(2);
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 299) == 0) fill(2);
         ld  = ($urandom_range(0, 15) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         cycle(ld, rdy, "rand");
      end
      drain("rand_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
